disp_mux_bcd: RTL



---
 rtl/disp_pkg.sv | 29 ++
 rtl/bcd_to_sseg.sv | 34 +++
 rtl/disp_mux_bcd.sv | 116 +++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared constants for the seven-segment display path.
// Segment byte order is {dp,g,f,e,d,c,b,a}; every pattern is active-low.
// Ports: none (package).
package disp_pkg;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned BCD_W  = 4;
    localparam int unsigned SEG_W  = 7;

    // Segment pin byte: dp in bit 7, seg holds {g,f,e,d,c,b,a}.
    typedef struct packed {
        logic             dp;
        logic [SEG_W-1:0] seg;
    } sseg_t;

    localparam logic [SEG_W-1:0] SSEG_0    = 7'h40;
    localparam logic [SEG_W-1:0] SSEG_1    = 7'h79;
    localparam logic [SEG_W-1:0] SSEG_2    = 7'h24;
    localparam logic [SEG_W-1:0] SSEG_3    = 7'h30;
    localparam logic [SEG_W-1:0] SSEG_4    = 7'h19;
    localparam logic [SEG_W-1:0] SSEG_5    = 7'h12;
    localparam logic [SEG_W-1:0] SSEG_6    = 7'h02;
    localparam logic [SEG_W-1:0] SSEG_7    = 7'h78;
    localparam logic [SEG_W-1:0] SSEG_8    = 7'h00;
    localparam logic [SEG_W-1:0] SSEG_9    = 7'h10;
    localparam logic [SEG_W-1:0] SSEG_DASH = 7'h3F;
    localparam logic [SEG_W-1:0] SSEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD digit to active-low 7-segment pattern.
// Ports: digit (4-bit BCD), blank (force all segments off),
//        seg_c (7-bit pattern {g,f,e,d,c,b,a}).
module bcd_to_sseg
    import disp_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             blank,
    output logic [SEG_W-1:0] seg_c
);

    // Non-BCD codes 10..15 fall through to a dash.
    always_comb begin
        seg_c = SSEG_DASH;
        if (blank) begin
            seg_c = SSEG_OFF;
        end else begin
            case (digit)
                4'd0:    seg_c = SSEG_0;
                4'd1:    seg_c = SSEG_1;
                4'd2:    seg_c = SSEG_2;
                4'd3:    seg_c = SSEG_3;
                4'd4:    seg_c = SSEG_4;
                4'd5:    seg_c = SSEG_5;
                4'd6:    seg_c = SSEG_6;
                4'd7:    seg_c = SSEG_7;
                4'd8:    seg_c = SSEG_8;
                4'd9:    seg_c = SSEG_9;
                default: seg_c = SSEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/disp_mux_bcd.sv
// Four-digit time-multiplexed seven-segment driver for a common-anode display.
// A free-running N-bit refresh counter scans one digit per 2^(N-2) clocks;
// digit values and decimal points are snapshotted once per scan so a carry
// in the stopwatch counters never tears the displayed value.
// Optional: define DISP_MUX_LZB_EN for leading-zero blanking of digits 3..1.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   en     display enable (0 gates anodes off, scanning continues)
//   in3..in0  BCD digits, most to least significant
//   dp_in  decimal point per digit, active-high
//   an     anode enables, active-low, bit i = digit i
//   sseg   segments, active-low {dp,g,f,e,d,c,b,a}
module disp_mux_bcd
    import disp_pkg::*;
#(
    parameter int unsigned N = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [BCD_W-1:0]  in3,
    input  logic [BCD_W-1:0]  in2,
    input  logic [BCD_W-1:0]  in1,
    input  logic [BCD_W-1:0]  in0,
    input  logic [DIGITS-1:0] dp_in,
    output logic [DIGITS-1:0] an,
    output logic [7:0]        sseg
);

    logic [N-1:0]        q_reg;
    logic [BCD_W-1:0]    s3, s2, s1, s0;
    logic [DIGITS-1:0]   sdp;
    logic [1:0]          sel_c;
    logic                scan_end_c;
    logic [BCD_W-1:0]    digit_c;
    logic                blank_c;
    logic [DIGITS-1:0]   blank_vec_c;
    logic [SEG_W-1:0]    seg_c;
    sseg_t               sseg_nxt_c;

    assign sel_c      = q_reg[N-1 -: 2];
    assign scan_end_c = &q_reg;

    // Refresh counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_reg + N'(1);
        end
    end

    // Snapshot on the last count of a scan; first shown in the next digit-0 slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s3  <= '0;
            s2  <= '0;
            s1  <= '0;
            s0  <= '0;
            sdp <= '0;
        end else if (scan_end_c) begin
            s3  <= in3;
            s2  <= in2;
            s1  <= in1;
            s0  <= in0;
            sdp <= dp_in;
        end
    end

    // Leading-zero blanking chains from the top digit down; digit 0 always shows.
`ifdef DISP_MUX_LZB_EN
    always_comb begin
        blank_vec_c    = '0;
        blank_vec_c[3] = (s3 == '0);
        blank_vec_c[2] = blank_vec_c[3] && (s2 == '0);
        blank_vec_c[1] = blank_vec_c[2] && (s1 == '0);
    end
`else
    assign blank_vec_c = '0;
`endif

    // Digit mux on the snapshot only.
    always_comb begin
        digit_c = s0;
        case (sel_c)
            2'd0: digit_c = s0;
            2'd1: digit_c = s1;
            2'd2: digit_c = s2;
            2'd3: digit_c = s3;
            default: digit_c = s0;
        endcase
    end

    assign blank_c = blank_vec_c[sel_c];

    bcd_to_sseg u_dec (
        .digit (digit_c),
        .blank (blank_c),
        .seg_c (seg_c)
    );

    assign sseg_nxt_c = '{dp: ~sdp[sel_c], seg: seg_c};

    // Pin registers: one clock behind sel; only the anodes honour en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an   <= 4'b1111;
            sseg <= 8'hFF;
        end else begin
            an   <= en ? 4'(~(4'b0001 << sel_c)) : 4'b1111;
            sseg <= sseg_nxt_c;
        end
    end

endmodule
